// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetch_state_e    : sequencer state encoding
//   INSTR_BYTES      : PC increment per instruction
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   WAIT_W           : width of the ack wait counter
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned WAIT_W           = 8;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register.
//   clock, reset_n : clock and asynchronous active-low reset (loads RESET_PC)
//   load, target   : load target into the PC (wins over incr)
//   incr           : advance the PC by one instruction, modulo 2^32
//   pc             : current PC
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        incr,
  output logic [31:0] pc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (incr) begin
      pc <= pc + 32'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, runs the req/ack handshake to
// instruction memory and presents one instruction at a time to decode.
//   clock, reset_n                  : clock, asynchronous active-low reset
//   run                             : fetch enable
//   stall                           : decode not ready, hold presented instr
//   redirect_valid, redirect_target : branch/jump redirect from execute
//   imem_req, imem_addr             : memory request and word address
//   imem_ack, imem_rdata            : memory completion and instruction word
//   instr_valid, instr, instr_pc    : instruction presented to decode
//   pc                              : next address to fetch
//   fetch_timeout                   : sticky memory timeout flag
//
// state | meaning
// IDLE  | not fetching; redirects still update the PC
// FETCH | request outstanding at pc, waiting for imem_ack
// ISSUE | instruction presented to decode until consumed or redirected
// ERR   | memory timed out; held until reset
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic        fetch_timeout
);

  fetch_state_e      state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pend_q;
  logic [31:0]       pend_tgt;
  logic              pc_load, pc_incr, take_instr;
  logic [31:0]       pc_target;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (pc_load),
    .target  (pc_target),
    .incr    (pc_incr),
    .pc      (pc)
  );

  // The address follows the PC, which only moves on ack, so it is stable
  // for the whole request.
  assign imem_addr = pc;

  always_comb begin
    state_nxt     = state;
    pc_load       = 1'b0;
    pc_incr       = 1'b0;
    pc_target     = word_align(redirect_target);
    take_instr    = 1'b0;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    fetch_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_load = redirect_valid;
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (pend_q || redirect_valid) begin
            // A same-cycle redirect is newer than the latched one.
            pc_load = 1'b1;
            if (!redirect_valid) pc_target = pend_tgt;
            state_nxt = run ? ST_FETCH : ST_IDLE;
          end else begin
            pc_incr    = 1'b1;
            take_instr = 1'b1;
            state_nxt  = ST_ISSUE;
          end
        end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          pc_load   = 1'b1;
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end else if (!stall) begin
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_ERR: begin
        fetch_timeout = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      pend_q   <= 1'b0;
      pend_tgt <= '0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nxt;
      // Counter is zero outside FETCH, so every FETCH entry starts from zero.
      if (state == ST_FETCH && !imem_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == ST_FETCH && !imem_ack) begin
        if (redirect_valid) begin
          pend_q   <= 1'b1;
          pend_tgt <= word_align(redirect_target);
        end
      end else begin
        pend_q <= 1'b0;
      end
      if (take_instr) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch sequencer for the CPU. It owns the program counter and drives a req/ack handshake to instruction memory.
- It presents one fetched instruction at a time to decode, with a stall handshake.
- It applies branch/jump redirects from execute.
- It sits between the instruction memory port and the decode stage, and replaces the free-running PC update.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 8, cycles FETCH may wait for imem_ack before flagging a timeout (range 1..255).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  fetch enable
- stall  in  1  decode not ready; holds the presented instruction
- redirect_valid  in  1  one-cycle pulse; load redirect_target
- redirect_target  in  32  new PC; bits [1:0] ignored (forced to 00)
- imem_req  out  1  memory request
- imem_addr  out  32  request address, word aligned
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr and instr_pc valid for decode
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- pc  out  32  current PC (next address to fetch)
- fetch_timeout  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, on reset_n low):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - fetch_timeout=0, wait count=0, redirect pending=0.
- States: IDLE, FETCH, ISSUE, ERR.
- IDLE:
  - Outputs: imem_req=0, instr_valid=0.
  - run=1 -> FETCH on the next cycle.
  - redirect_valid -> pc<=target; state stays IDLE.
- FETCH:
  - Outputs: imem_req=1, imem_addr=pc. Address stays stable until ack is sampled; the request is never withdrawn before ack.
  - Wait count increments on every FETCH cycle without ack.
  - imem_ack with no pending redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, -> ISSUE.
  - redirect_valid before ack: set the pending flag and latch the target. Later redirects overwrite the latched target.
  - On ack with pending (or same-cycle redirect_valid): discard data, pc<=target, clear pending. Then -> FETCH if run=1, else -> IDLE.
  - Wait count reaching MAX_WAIT without ack -> ERR.
- ISSUE:
  - Outputs: instr_valid=1, imem_req=0.
  - stall=1: hold instr, instr_pc and instr_valid unchanged.
  - stall=0: instruction consumed this cycle. Then -> FETCH if run=1, else -> IDLE.
  - redirect_valid (with or without stall): drop the instruction (instr_valid=0 next cycle), pc<=target, -> FETCH if run=1, else -> IDLE.
- ERR:
  - Outputs: imem_req=0, instr_valid=0, fetch_timeout=1.
  - Stays in ERR until reset; all inputs are ignored.
- run deasserted mid-FETCH: the transaction completes, the result is issued, then -> IDLE.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0.
- Throughput: 2 cycles per instruction with zero-wait memory (ack in the first FETCH cycle).
- Latency: instr_valid rises the cycle after ack.
- Wait count clears on entry to FETCH.
- Reset asserted mid-transaction: imem_req drops immediately (asynchronous); memory must tolerate an abandoned request.

Decomposition:
- Package fetch_pkg holds:
  - the state encoding (IDLE, FETCH, ISSUE, ERR);
  - INSTR_BYTES=4;
  - the default RESET_PC;
  - the wait-counter width (8).
- Sub-module fetch_pc_reg: 32-bit PC register with asynchronous active-low reset to RESET_PC, load (target) and increment (+4) controls, load taking priority.
- The FSM, wait counter and pending-redirect flag stay in fetch_seq.

Test Plan:
- Reset, run=1, memory acks in the first FETCH cycle: imem_addr sequence 0,4,8; instr_valid high every second cycle; instr_pc matches each address.
- stall=1 for 3 cycles while in ISSUE: instr/instr_pc held and no imem_req; after stall drops, the next request is to instr_pc+4.
- redirect_valid to 32'h0000_0103 two cycles into a 4-cycle-wait fetch at 0x10: data for 0x10 is discarded with no instr_valid; the next request is to 0x100.
- pc=32'hFFFF_FFFC with an ack: pc becomes 0 and the next request is to 0.
- No ack for MAX_WAIT=8 cycles: fetch_timeout=1, imem_req=0; stays set despite later acks or redirects; clears only on reset_n low.
- reset_n pulsed low during FETCH: imem_req falls immediately and pc=RESET_PC; fetch resumes from RESET_PC once run=1.
